param_data_cache: RTL

PARAM_DATA_CACHE -- requirements
Module: param_data_cache

---
 rtl/param_data_cache_pkg.sv | 34 +++
 rtl/param_data_cache_array.sv | 34 +++
 rtl/param_data_cache.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/param_data_cache_pkg.sv
// Shared types and derived-width helpers for the direct-mapped write-back data cache.
package param_data_cache_pkg;

  typedef enum logic [1:0] {StIdle, StWriteback, StRefill, StRespond} state_e;

  localparam int unsigned BYTE_OFF_W = 2;
  localparam int unsigned WORD_W     = 32;

  localparam int unsigned DEF_ADDR_W     = 32;
  localparam int unsigned DEF_INDEX_W    = 4;
  localparam int unsigned DEF_WORD_OFF_W = 4;

  function automatic int unsigned tag_width(input int unsigned addr_w, input int unsigned index_w,
                                            input int unsigned word_off_w);
    return addr_w - index_w - word_off_w - BYTE_OFF_W;
  endfunction

  function automatic int unsigned words_per_line(input int unsigned word_off_w);
    return 32'd1 << word_off_w;
  endfunction

  // LSB positions of the word-offset and index fields within a byte address.
  function automatic int unsigned word_lsb();
    return BYTE_OFF_W;
  endfunction

  function automatic int unsigned index_lsb(input int unsigned word_off_w);
    return BYTE_OFF_W + word_off_w;
  endfunction

  localparam int unsigned TAG_W = tag_width(DEF_ADDR_W, DEF_INDEX_W, DEF_WORD_OFF_W);
  localparam int unsigned WORDS = words_per_line(DEF_WORD_OFF_W);

endpackage

// File: rtl/param_data_cache_array.sv
// Data RAM for the cache: two combinational read ports, one byte-enabled write port.
module param_data_cache_array
  import param_data_cache_pkg::*;
#(
  parameter int unsigned INDEX_W    = 4,
  parameter int unsigned WORD_OFF_W = 4
) (
  input  logic                          clk_i,
  input  logic [INDEX_W+WORD_OFF_W-1:0] rd_a_addr_i,
  output logic [WORD_W-1:0]             rd_a_data_o,
  input  logic [INDEX_W+WORD_OFF_W-1:0] rd_b_addr_i,
  output logic [WORD_W-1:0]             rd_b_data_o,
  input  logic                          wr_en_i,
  input  logic [INDEX_W+WORD_OFF_W-1:0] wr_addr_i,
  input  logic [3:0]                    wr_be_i,
  input  logic [WORD_W-1:0]             wr_data_i
);

  localparam int unsigned Depth = 2 ** (INDEX_W + WORD_OFF_W);

  logic [WORD_W-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be_i[b]) mem_q[wr_addr_i][8*b +: 8] <= wr_data_i[8*b +: 8];
      end
    end
  end

  assign rd_a_data_o = mem_q[rd_a_addr_i];
  assign rd_b_data_o = mem_q[rd_b_addr_i];

endmodule

// File: rtl/param_data_cache.sv
// Direct-mapped, write-back, write-allocate data cache with a beat-serial memory port.
// Define PARAM_DATA_CACHE_STATS_EN to add saturating hit_count / miss_count outputs.
module param_data_cache
  import param_data_cache_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned INDEX_W    = 4,
  parameter int unsigned WORD_OFF_W = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_be,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_hit,
  output logic              cpu_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
`ifdef PARAM_DATA_CACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int unsigned TagW  = tag_width(ADDR_W, INDEX_W, WORD_OFF_W);
  localparam int unsigned Lines = 2 ** INDEX_W;

  logic [TagW-1:0]       req_tag;
  logic [INDEX_W-1:0]    index;
  logic [WORD_OFF_W-1:0] word;
  logic                  unused_byte_off;

  assign req_tag         = cpu_addr[ADDR_W-1 -: TagW];
  assign index           = cpu_addr[index_lsb(WORD_OFF_W) +: INDEX_W];
  assign word            = cpu_addr[word_lsb() +: WORD_OFF_W];
  assign unused_byte_off = ^cpu_addr[1:0];

  state_e                state_q, state_d;
  logic [WORD_OFF_W-1:0] beat_q, beat_d;
  logic [Lines-1:0]      valid_q, valid_d, dirty_q, dirty_d;
  logic [TagW-1:0]       tag_q [Lines];
  logic                  tag_we, hit, stall_raw, store_hit;

  logic                          arr_wr_en;
  logic [INDEX_W+WORD_OFF_W-1:0] arr_wr_addr;
  logic [3:0]                    arr_wr_be;
  logic [31:0]                   arr_wr_data;

  assign hit     = valid_q[index] && (tag_q[index] == req_tag);
  assign cpu_hit = hit;
  // Reset forces a quiet CPU interface even while cpu_req is still asserted.
  assign cpu_stall = stall_raw & reset_n;

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    tag_we      = 1'b0;
    stall_raw   = 1'b0;
    store_hit   = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = {req_tag, index, beat_q, 2'b00};
    arr_wr_en   = 1'b0;
    arr_wr_addr = {index, word};
    arr_wr_be   = cpu_be;
    arr_wr_data = cpu_wdata;
    unique case (state_q)
      StIdle: begin
        if (cpu_req) begin
          if (hit) begin
            store_hit = cpu_we;
          end else begin
            stall_raw      = 1'b1;
            beat_d         = '0;
            // Line is being replaced: never let a half-refilled line look valid.
            valid_d[index] = 1'b0;
            state_d        = (valid_q[index] && dirty_q[index]) ? StWriteback : StRefill;
          end
        end
      end
      StWriteback: begin
        stall_raw = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_q[index], index, beat_q, 2'b00};
        if (mem_ack) begin
          beat_d = beat_q + 1'b1;
          if (&beat_q) begin
            dirty_d[index] = 1'b0;
            state_d        = StRefill;
          end
        end
      end
      StRefill: begin
        stall_raw = 1'b1;
        mem_req   = 1'b1;
        if (mem_ack) begin
          arr_wr_en   = 1'b1;
          arr_wr_addr = {index, beat_q};
          arr_wr_be   = 4'hf;
          arr_wr_data = mem_rdata;
          beat_d      = beat_q + 1'b1;
          if (&beat_q) begin
            valid_d[index] = 1'b1;
            tag_we         = 1'b1;
            state_d        = StRespond;
          end
        end
      end
      StRespond: begin
        store_hit = cpu_req & cpu_we;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (store_hit) begin
      arr_wr_en      = 1'b1;
      dirty_d[index] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      beat_q  <= '0;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  always_ff @(posedge clock) begin
    if (tag_we) tag_q[index] <= req_tag;
  end

  param_data_cache_array #(
    .INDEX_W    (INDEX_W),
    .WORD_OFF_W (WORD_OFF_W)
  ) u_array (
    .clk_i       (clock),
    .rd_a_addr_i ({index, word}),
    .rd_a_data_o (cpu_rdata),
    .rd_b_addr_i ({index, beat_q}),
    .rd_b_data_o (mem_wdata),
    .wr_en_i     (arr_wr_en),
    .wr_addr_i   (arr_wr_addr),
    .wr_be_i     (arr_wr_be),
    .wr_data_i   (arr_wr_data)
  );

`ifdef PARAM_DATA_CACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == StIdle && cpu_req) begin
      if (hit && hit_cnt_q != 32'hffff_ffff) hit_cnt_d = hit_cnt_q + 32'd1;
      if (!hit && miss_cnt_q != 32'hffff_ffff) miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule
